// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   SZ_*      : access size encodings on req_size
//   lsu_state_e : control FSM states
//   FLT_*     : fault cause recorded with a response (FLT_NONE = no fault)
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_SIZE     = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

endpackage

// File: rtl/lsu_extract.sv
// lsu_extract: combinational load-data alignment and extension.
//   hi, lo : upper/lower bus words (hi = 0 for a single-beat access)
//   off    : byte offset of the access inside lo
//   size   : access size (SZ_*)
//   uns    : 1 = zero-extend, 0 = sign-extend
//   data   : right-justified, extended load value
module lsu_extract
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [OFFW-1:0] off,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);

    logic [2*XLEN-1:0] wide;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   keep;
    logic              sign;
    int                nbits;

    always_comb begin
        wide  = {hi, lo} >> {off, 3'b000};
        raw   = wide[XLEN-1:0];
        nbits = 8 << size;
        keep  = '1;
        if (nbits < XLEN) keep = (XLEN'(1) << nbits) - XLEN'(1);
        // The sign bit is the top bit of the kept field: keep & ~(keep >> 1).
        sign  = |(raw & keep & ~(keep >> 1));
        data  = (raw & keep) | ((sign && !uns) ? ~keep : '0);
    end

endmodule

// File: rtl/lsu_multicycle.sv
// lsu_multicycle: load/store unit between the datapath and a word-wide
// valid/ready memory port.
//   req_*  : one request at a time, accepted when req_ready (IDLE only)
//   resp_* : one-cycle completion pulse with extended load data and fault
//   mem_*  : registered bus request; mem_rdata valid with mem_ready
// Misaligned accesses are split into two beats (SPLIT_MISALIGNED=1) or
// faulted without a bus access. A beat waiting MAX_WAIT cycles is aborted.
module lsu_multicycle
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1,
    parameter int MAX_WAIT         = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int BYTES  = XLEN / 8;
    localparam int OFFW   = $clog2(BYTES);
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    // ---- request decode (valid only while IDLE) ----
    logic [OFFW-1:0]    req_off;
    logic [ADDR_W-1:0]  req_base;
    logic [BYTES-1:0]   req_mask;
    logic [2*BYTES-1:0] be_wide;
    logic [2*XLEN-1:0]  wd_wide;
    logic               req_mis, req_cross, req_illegal;
    int                 req_nb;

    always_comb begin
        req_off     = req_addr[OFFW-1:0];
        req_base    = req_addr & ~ADDR_W'(BYTES - 1);
        req_nb      = 1 << req_size;
        req_illegal = (req_size == SZ_D) && (XLEN == 32);
        req_mis     = (int'(req_off) & (req_nb - 1)) != 0;
        req_cross   = (int'(req_off) + req_nb) > BYTES;
        req_mask    = '1;
        if (req_nb < BYTES) req_mask = BYTES'((1 << req_nb) - 1);
        // Low half feeds beat 0, high half is what spills into beat 1.
        be_wide     = {{BYTES{1'b0}}, req_mask} << req_off;
        wd_wide     = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    end

    // ---- state ----
    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]        cause_q, cause_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BYTES-1:0]  mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              cross_q, cross_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BYTES-1:0]  be1_q, be1_d;
    logic [XLEN-1:0]   wdata1_q, wdata1_d;
    logic [XLEN-1:0]   rbuf0_q, rbuf0_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // ---- load data path ----
    logic            two_beat;
    logic [XLEN-1:0] ext_hi, ext_lo, ext_data;

    assign two_beat = (state_q == S_BEAT1);
    assign ext_hi   = two_beat ? mem_rdata : '0;
    assign ext_lo   = two_beat ? rbuf0_q : mem_rdata;

    lsu_extract #(.XLEN(XLEN), .OFFW(OFFW)) u_extract (
        .hi   (ext_hi),
        .lo   (ext_lo),
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .data (ext_data)
    );

    logic hs, stalled, tmo;

    always_comb begin
        hs      = mem_valid_q && mem_ready;
        stalled = mem_valid_q && !mem_ready;
        tmo     = stalled && (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        cause_d      = cause_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        cross_d      = cross_q;
        base_d       = base_q;
        be1_d        = be1_q;
        wdata1_d     = wdata1_q;
        rbuf0_d      = rbuf0_q;
        wait_d       = (stalled && !tmo) ? wait_q + WAIT_W'(1) : '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_off;
                    cross_d     = req_cross;
                    base_d      = req_base;
                    be1_d       = be_wide[2*BYTES-1:BYTES];
                    wdata1_d    = wd_wide[2*XLEN-1:XLEN];
                    if (req_illegal || (req_mis && SPLIT_MISALIGNED == 0)) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        cause_d      = req_illegal ? FLT_SIZE : FLT_MISALIGN;
                    end else begin
                        state_d     = S_BEAT0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_base;
                        mem_be_d    = be_wide[BYTES-1:0];
                        mem_wdata_d = wd_wide[XLEN-1:0];
                    end
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (state_q == S_BEAT1 && !mem_valid_q) begin
                    // One idle bus cycle separates the beats; launch beat 1 now.
                    mem_valid_d = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'(BYTES);
                    mem_be_d    = be1_q;
                    mem_wdata_d = wdata1_q;
                end else if (hs) begin
                    mem_valid_d = 1'b0;
                    rbuf0_d     = (state_q == S_BEAT0) ? mem_rdata : rbuf0_q;
                    if (state_q == S_BEAT0 && cross_q) begin
                        state_d = S_BEAT1;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? '0 : ext_data;
                        cause_d      = FLT_NONE;
                    end
                end else if (tmo) begin
                    // Abort; a completed beat-0 store is not rolled back.
                    mem_valid_d  = 1'b0;
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    cause_d      = FLT_TIMEOUT;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_rdata_d = '0;
                cause_d      = FLT_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            cause_q      <= FLT_NONE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= '0;
            cross_q      <= 1'b0;
            base_q       <= '0;
            be1_q        <= '0;
            wdata1_q     <= '0;
            rbuf0_q      <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            cause_q      <= cause_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            cross_q      <= cross_d;
            base_q       <= base_d;
            be1_q        <= be1_d;
            wdata1_q     <= wdata1_d;
            rbuf0_q      <= rbuf0_d;
            wait_q       <= wait_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = (cause_q != FLT_NONE);
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
Parametrised load/store unit for the multi-cycle RISC-V core. It sits between the datapath (ALU address, rs2 store data, writeback buffer) and a word-wide memory port with a valid/ready handshake. It replaces the fixed byte/half mux-and-extend path with proper byte enables, lane alignment and sign/zero extension. It also adds optional splitting of misaligned accesses into two beats and a bus-timeout fault.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; BYTES = XLEN/8, OFFW = log2(BYTES)
ADDR_W, 32, address width
SPLIT_MISALIGNED, 1, 1 = split a misaligned access into two beats; 0 = fault without a bus access
MAX_WAIT, 15, cycles mem_valid may stay high without mem_ready before abort; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  datapath request
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64; otherwise fault)
req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores
resp_fault  out  1  valid with resp_valid: misaligned (SPLIT=0), illegal size, or timeout
mem_valid  out  1  bus request
mem_ready  in  1  bus accept/complete; for reads, mem_rdata is valid in the same cycle
mem_we  out  1  bus write
mem_addr  out  ADDR_W  aligned address, low OFFW bits = 0
mem_be  out  BYTES  byte enables
mem_wdata  out  XLEN  lane-shifted store data
mem_rdata  in  XLEN  bus read data

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except req_ready=1. Wait counter and beat-0 read buffer cleared. Any in-flight access is abandoned and produces no response.
- Request fields are captured on req_valid && req_ready. All mem_* outputs are registered.
- Definitions: off = addr[OFFW-1:0]; nb = 1<<size; mask = (1<<nb)-1; misaligned = (off & (nb-1)) != 0; crosses = off + nb > BYTES.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE -> RESP with fault=1 on an illegal size, or when misaligned and SPLIT_MISALIGNED=0. No mem_valid is raised.
- Otherwise IDLE -> BEAT0. The cycle after acceptance, mem_valid=1 with:
  - mem_addr = addr & ~(BYTES-1)
  - mem_be = (mask<<off) truncated to BYTES bits
  - mem_wdata = wdata << 8*off
- BEAT0 on mem_ready: latch mem_rdata into rbuf0. If crosses, go to BEAT1; else go to RESP. mem_valid drops for one cycle between beats.
- BEAT1: mem_addr = aligned address + BYTES, mem_be = mask >> (BYTES-off), mem_wdata = wdata >> 8*(BYTES-off). On mem_ready, go to RESP.
- mem_addr wraps modulo 2^ADDR_W at the top of memory.
- Handshake: mem_* outputs stay stable while mem_valid=1 and mem_ready=0.
- Load data path:
  - Two-beat: raw = {mem_rdata_beat1, rbuf0} >> 8*off.
  - Single-beat: raw = mem_rdata >> 8*off.
  - Take the low 8*nb bits of raw, then sign- or zero-extend per req_unsigned.
- RESP (exactly 1 cycle): resp_valid=1 with resp_rdata and resp_fault, then -> IDLE with req_ready=1. The response has no back-pressure.
- Timeout: the counter increments each cycle mem_valid=1 && mem_ready=0 and clears on each handshake. If it reaches MAX_WAIT, drop mem_valid and go to RESP with fault=1 and rdata=0. A beat-1 timeout after a completed beat-0 store still faults; no rollback is performed.
- Latency (aligned, zero-wait): accept at cycle N, mem_valid at N+1, resp_valid at N+2. A split access with zero wait states gives resp_valid at N+4.
- A req_valid seen while not in IDLE is ignored, because req_ready=0.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state enum
  - fault-cause constants (FLT_MISALIGN, FLT_SIZE, FLT_TIMEOUT)
- One natural sub-module, lsu_extract: purely combinational {hi,lo}, off, size, unsigned -> extended load data. It is reused by the future cache refill path.

Test Plan:
- Word store, addr 0x100, wdata 0xDEADBEEF, zero wait -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF at N+1; resp_valid at N+2, fault=0.
- LB at 0x103, mem_rdata 0x80_112233 -> resp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SPLIT=1, LH at 0x107, beat0 rdata 0xAB000000, beat1 rdata 0x000000CD -> two beats (addrs 0x104 be=1000, 0x108 be=0001); resp_rdata=0xFFFFCDAB.
- SPLIT=0, SW at 0x102 -> mem_valid never asserts; resp_valid with fault=1 at N+1.
- MAX_WAIT=4, mem_ready held 0 -> mem_valid high 4 cycles then drops; resp fault=1, rdata=0.
- rst pulled low while in BEAT1 -> mem_valid=0 immediately, no resp_valid; after release, req_ready=1 and the next aligned LW completes normally.
